// File: rtl/param_commit_scheduler.sv
// -----------------------------------------------------------------------------
// param_commit_scheduler
//
// Buffers host parameter writes (from the SPI memory interface) in a small FIFO
// and releases them to the param_mem write port only inside the per-frame commit
// window [COMMIT_START, 2^PC_WIDTH-1]. This keeps the dsp_core from ever seeing a
// coefficient set that is half-updated in the middle of a frame. At most
// MAX_PER_FRAME writes are issued per frame. Host writes that arrive while the
// FIFO is full are dropped and raise a sticky overflow flag.
//
// Optional feature: define PARAM_COMMIT_DROP_COUNT_EN to add a saturating 16-bit
// drop_count output, which counts dropped host writes and is cleared by ovf_clear.
//
// Ports
//   dsp_clk        in   DSP clock
//   reset_n        in   asynchronous active-low reset
//   pc             in   DSP program counter, wraps to 0 at each frame start
//   host_wr_en     in   host write strobe, one cycle per word
//   host_wr_addr   in   host write address
//   host_wr_data   in   host write data
//   host_ready     out  FIFO can accept a write this cycle (not full)
//   ovf_clear      in   clears overflow (and drop_count when enabled)
//   overflow       out  sticky: a host write was dropped
//   param_wr_en    out  param_mem write enable, one cycle per committed entry
//   param_wr_addr  out  param_mem write address
//   param_wr_data  out  param_mem write data
//   pending        out  FIFO occupancy, 0..FIFO_DEPTH
//   drop_count     out  dropped write count (only with PARAM_COMMIT_DROP_COUNT_EN)
// -----------------------------------------------------------------------------
module param_commit_scheduler #(
    parameter int ADDR_WIDTH    = 10,
    parameter int WORD_WIDTH    = 36,
    parameter int PC_WIDTH      = 11,
    parameter int FIFO_DEPTH    = 16,
    parameter int COMMIT_START  = 2016,
    parameter int MAX_PER_FRAME = 16
) (
    input  logic                          dsp_clk,
    input  logic                          reset_n,
    input  logic [PC_WIDTH-1:0]           pc,
    input  logic                          host_wr_en,
    input  logic [ADDR_WIDTH-1:0]         host_wr_addr,
    input  logic [WORD_WIDTH-1:0]         host_wr_data,
    output logic                          host_ready,
    input  logic                          ovf_clear,
    output logic                          overflow,
    output logic                          param_wr_en,
    output logic [ADDR_WIDTH-1:0]         param_wr_addr,
    output logic [WORD_WIDTH-1:0]         param_wr_data,
`ifdef PARAM_COMMIT_DROP_COUNT_EN
    output logic [15:0]                   drop_count,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   pending
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int FCNT_W = $clog2(MAX_PER_FRAME + 1);
    localparam int ENT_W  = ADDR_WIDTH + WORD_WIDTH;

    localparam logic [PC_WIDTH-1:0] PC_START = PC_WIDTH'(COMMIT_START);
    localparam logic [PC_WIDTH-1:0] PC_LAST  = '1;
    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [FCNT_W-1:0]   FMAX     = FCNT_W'(MAX_PER_FRAME);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_COMMIT = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_WIDTH-1:0] wr_data_q, wr_data_d;

    // Entry storage: no reset so it maps onto distributed/block RAM.
    logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];

    logic                push;
    logic                drop;
    logic                window_open;
    logic [FCNT_W-1:0]   budget_used;
    logic                pop;
    logic [ENT_W-1:0]    head_entry;

    // host_ready comes from the registered count, so a full FIFO refuses a push
    // even in a cycle where it also pops (no bypass).
    assign host_ready = (count_q != FULL_CNT);
    assign push       = host_wr_en && host_ready;
    assign drop       = host_wr_en && !host_ready;
    assign head_entry = mem_q[head_q];

    // The cycle with pc == COMMIT_START already belongs to the window, so the
    // first pop happens while the FSM is still in WAIT; the per-frame budget is
    // treated as fresh in that cycle.
    assign window_open = (state_q == S_COMMIT) ||
                         ((state_q == S_WAIT) && (pc == PC_START));
    assign budget_used = (state_q == S_COMMIT) ? frame_cnt_q : '0;
    assign pop         = window_open && (count_q != '0) && (budget_used < FMAX);

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        wr_en_d     = pop;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d    = head_q + PTR_W'(1);
            wr_addr_d = head_entry[ENT_W-1:WORD_WIDTH];
            wr_data_d = head_entry[WORD_WIDTH-1:0];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Set wins over clear.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            S_WAIT, S_COMMIT: begin
                if (window_open) begin
                    frame_cnt_d = budget_used + FCNT_W'(pop);
                    state_d     = ((frame_cnt_d == FMAX) || (pc == PC_LAST)) ? S_DONE : S_COMMIT;
                end
            end
            S_DONE: begin
                if (pc == '0) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_WAIT;
            frame_cnt_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_ff @(posedge dsp_clk) begin
        if (push) begin
            mem_q[tail_q] <= {host_wr_addr, host_wr_data};
        end
    end

    assign overflow      = ovf_q;
    assign param_wr_en   = wr_en_q;
    assign param_wr_addr = wr_addr_q;
    assign param_wr_data = wr_data_q;
    assign pending       = count_q;

`ifdef PARAM_COMMIT_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Clear wins over increment; saturates instead of wrapping.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_clear) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_param_commit_scheduler.sv
// -----------------------------------------------------------------------------
// tb_param_commit_scheduler
//
// Drives a free-running pc and host write traffic into param_commit_scheduler.
// A queue-based model tracks buffered words, the commit window and the per-frame
// write budget; a compare process checks every DUT output against it each cycle
// on the falling edge. Directed scenarios add literal expectations on the write
// log (pc, address, data of every param_mem write).
// MAX_PER_FRAME is set to 4 so the per-frame limit is exercised.
// -----------------------------------------------------------------------------
module tb_param_commit_scheduler;

    localparam int AW    = 10;
    localparam int WW    = 36;
    localparam int PCW   = 11;
    localparam int DEPTH = 16;
    localparam int CS    = 2016;
    localparam int MAXF  = 4;
    localparam int LASTPC = 2047;

    logic            dsp_clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [PCW-1:0]  pc = '0;
    logic            host_wr_en = 1'b0;
    logic [AW-1:0]   host_wr_addr = '0;
    logic [WW-1:0]   host_wr_data = '0;
    logic            ovf_clear = 1'b0;
    logic            host_ready;
    logic            overflow;
    logic            param_wr_en;
    logic [AW-1:0]   param_wr_addr;
    logic [WW-1:0]   param_wr_data;
    logic [4:0]      pending;
`ifdef PARAM_COMMIT_DROP_COUNT_EN
    logic [15:0]     drop_count;
`endif

    param_commit_scheduler #(
        .ADDR_WIDTH   (AW),
        .WORD_WIDTH   (WW),
        .PC_WIDTH     (PCW),
        .FIFO_DEPTH   (DEPTH),
        .COMMIT_START (CS),
        .MAX_PER_FRAME(MAXF)
    ) dut (
        .dsp_clk      (dsp_clk),
        .reset_n      (reset_n),
        .pc           (pc),
        .host_wr_en   (host_wr_en),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .host_ready   (host_ready),
        .ovf_clear    (ovf_clear),
        .overflow     (overflow),
        .param_wr_en  (param_wr_en),
        .param_wr_addr(param_wr_addr),
        .param_wr_data(param_wr_data),
`ifdef PARAM_COMMIT_DROP_COUNT_EN
        .drop_count   (drop_count),
`endif
        .pending      (pending)
    );

    always #5 dsp_clk = ~dsp_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (pc=%0d t=%0t)", name, act, exp, pc, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [AW+WW-1:0] mq[$];        // buffered words, oldest first
    logic             m_ovf;
    logic [15:0]      m_drop;
    logic             m_wr_en;
    logic [AW-1:0]    m_addr;
    logic [WW-1:0]    m_data;
    logic             m_in_window;  // inside this frame's window, entered at exact pc==CS
    int               m_commits;    // writes committed in the current frame

    task automatic model_clear();
        mq.delete();
        m_ovf       = 1'b0;
        m_drop      = '0;
        m_wr_en     = 1'b0;
        m_addr      = '0;
        m_data      = '0;
        m_in_window = 1'b0;
        m_commits   = 0;
    endtask

    task automatic model_step();
        int occ;
        logic [AW+WW-1:0] e;
        logic take;
        occ = mq.size();
        if (int'(pc) == CS) begin
            m_in_window = 1'b1;
            m_commits   = 0;
        end
        take    = m_in_window && (m_commits < MAXF) && (occ > 0);
        m_wr_en = take;
        if (take) begin
            e = mq.pop_front();
            m_addr = e[AW+WW-1:WW];
            m_data = e[WW-1:0];
            m_commits++;
        end
        if (host_wr_en && occ < DEPTH) mq.push_back({host_wr_addr, host_wr_data});
        if (host_wr_en && occ == DEPTH) m_ovf = 1'b1;
        else if (ovf_clear) m_ovf = 1'b0;
        if (ovf_clear) m_drop = '0;
        else if (host_wr_en && occ == DEPTH && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        if (int'(pc) == LASTPC) m_in_window = 1'b0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge dsp_clk or negedge reset_n);
            if (!reset_n) model_clear();
            else model_step();
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    logic [PCW-1:0] lpc[$];
    logic [AW-1:0]  laddr[$];
    logic [WW-1:0]  ldata[$];

    initial begin
        forever begin
            @(negedge dsp_clk);
            chk("host_ready", 64'(host_ready), 64'(mq.size() != DEPTH));
            chk("pending", 64'(pending), 64'(mq.size()));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("param_wr_en", 64'(param_wr_en), 64'(m_wr_en));
            if (m_wr_en) begin
                chk("param_wr_addr", 64'(param_wr_addr), 64'(m_addr));
                chk("param_wr_data", 64'(param_wr_data), 64'(m_data));
            end
`ifdef PARAM_COMMIT_DROP_COUNT_EN
            chk("drop_count", 64'(drop_count), 64'(m_drop));
`endif
            if (param_wr_en) begin
                lpc.push_back(pc);
                laddr.push_back(param_wr_addr);
                ldata.push_back(param_wr_data);
                $display("write pc=%0d addr=%0d data=0x%0h", pc, param_wr_addr, param_wr_data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // One call = one clock cycle; the new pc and inputs are applied 1 time unit
    // after the rising edge and hold for the whole cycle.
    task automatic step(input logic we, input logic [AW-1:0] a, input logic [WW-1:0] d, input logic clr);
        @(posedge dsp_clk);
        #1;
        pc           = pc + 1'b1;
        host_wr_en   = we;
        host_wr_addr = a;
        host_wr_data = d;
        ovf_clear    = clr;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic push(input int a, input int d);
        step(1'b1, AW'(a), WW'(d), 1'b0);
    endtask

    // Advance until the current cycle's pc equals t (at most one frame).
    task automatic run_to(input int t);
        while (int'(pc) != t) idle();
    endtask

    task automatic log_clear();
        lpc.delete();
        laddr.delete();
        ldata.delete();
    endtask

    // ---------------- directed + random scenarios ----------------
    initial begin
        logic [WW-1:0] rd;
        repeat (3) idle();
        reset_n = 1'b1;
        chk("rst_host_ready", 64'(host_ready), 64'd1);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_wr_en", 64'(param_wr_en), 64'd0);

        // 1: three writes at pc=100..102, committed at 2017..2019 in order
        run_to(99);
        push(5, 1);
        push(6, 2);
        push(5, 3);
        idle();
        chk("t1_pending_buffered", 64'(pending), 64'd3);
        log_clear();
        run_to(LASTPC);
        chk("t1_no_early_write", 64'(lpc.size()), 64'd3);
        run_to(10);
        chk("t1_count", 64'(lpc.size()), 64'd3);
        chk("t1_pc0", 64'(lpc[0]), 64'd2017);
        chk("t1_pc1", 64'(lpc[1]), 64'd2018);
        chk("t1_pc2", 64'(lpc[2]), 64'd2019);
        chk("t1_a0", 64'(laddr[0]), 64'd5);
        chk("t1_d0", 64'(ldata[0]), 64'd1);
        chk("t1_a1", 64'(laddr[1]), 64'd6);
        chk("t1_d2", 64'(ldata[2]), 64'd3);
        chk("t1_pending_end", 64'(pending), 64'd0);

        // 2: 20 back-to-back writes, 4 dropped
        run_to(99);
        for (int i = 0; i < 20; i++) push(i, 256 + i);
        idle();
        chk("t2_pending_full", 64'(pending), 64'd16);
        chk("t2_host_ready", 64'(host_ready), 64'd0);
        chk("t2_overflow", 64'(overflow), 64'd1);
`ifdef PARAM_COMMIT_DROP_COUNT_EN
        chk("t2_drop_count", 64'(drop_count), 64'd4);
`endif
        step(1'b0, '0, '0, 1'b1);
        idle();
        chk("t2_ovf_cleared", 64'(overflow), 64'd0);

        // 3: 16 buffered, 4 writes per frame over 4 frames, in order
        log_clear();
        for (int f = 0; f < 4; f++) begin
            run_to(LASTPC);
            run_to(10);
            chk("t3_writes_so_far", 64'(lpc.size()), 64'(4 * (f + 1)));
        end
        for (int i = 0; i < 16; i++) chk("t3_order", 64'(laddr[i]), 64'(i));
        chk("t3_pending_end", 64'(pending), 64'd0);

        // 4: push into window with empty FIFO; push+pop keeps pending
        log_clear();
        run_to(2029);
        push(100, 7);
        push(101, 8);
        push(102, 9);
        chk("t4_pending_steady", 64'(pending), 64'd1);
        run_to(2040);
        chk("t4_count", 64'(lpc.size()), 64'd3);
        chk("t4_first_pc", 64'(lpc[0]), 64'd2032);
        chk("t4_first_addr", 64'(laddr[0]), 64'd100);
        chk("t4_last_pc", 64'(lpc[2]), 64'd2034);

        // 5: reset mid-window with 10 pending
        run_to(10);
        run_to(99);
        for (int i = 0; i < 12; i++) push(300 + i, i);
        run_to(2018);
        chk("t5_pending_before", 64'(pending), 64'd10);
        #1 reset_n = 1'b0;
        #1;
        chk("t5_wr_en_rst", 64'(param_wr_en), 64'd0);
        chk("t5_pending_rst", 64'(pending), 64'd0);
        chk("t5_ready_rst", 64'(host_ready), 64'd1);
        idle();
        idle();
        reset_n = 1'b1;
        log_clear();
        run_to(LASTPC);
        run_to(100);
        chk("t5_no_writes", 64'(lpc.size()), 64'd0);

        // 6: last-cycle pop lands at pc=0; push at 2047 waits for next window
        log_clear();
        run_to(2045);
        push(200, 11);
        push(201, 12);
        run_to(1);
        chk("t6_count_a", 64'(lpc.size()), 64'd1);
        chk("t6_pc0", 64'(lpc[0]), 64'd0);
        chk("t6_addr0", 64'(laddr[0]), 64'd200);
        run_to(2020);
        chk("t6_count_b", 64'(lpc.size()), 64'd2);
        chk("t6_pc1", 64'(lpc[1]), 64'd2017);
        chk("t6_addr1", 64'(laddr[1]), 64'd201);

        // Random traffic over three frames, model-checked every cycle
        for (int c = 0; c < 3 * 2048; c++) begin
            rd = {4'($urandom), $urandom};
            step(($urandom_range(0, 29) == 0), AW'($urandom), rd, ($urandom_range(0, 199) == 0));
        end
        repeat (4) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
